uart_tx_frame: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 byte transmitter. It adds configurable data width, stop-bit count and optional parity, plus a valid/ready input handshake that allows back-to-back frames with no idle gap. It sits between a byte or word producer (FIFO, command sequencer) and the board TX pin. It emits a one-cycle done pulse per completed frame.

---
 rtl/uart_tx_frame.sv | 117 +++++++++++
 tb/tb_uart_tx_frame.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (5..9 data bits, 1/2 stop) with valid/ready input.
// Define UART_TX_PARITY_EN to add a parity bit whose sense is set by PARITY_ODD.
module uart_tx_frame #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_sysclk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_uart_tx,
  output logic                 o_uart_tx_done
);
  localparam int BAUD_DIV = CLOCK_FREQ / BAUD;
  localparam int BDW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BDW-1:0] BLAST = BDW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter set");
  end
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_nxt;
  logic [BDW-1:0] baud_cnt, baud_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, sh_nxt;
  logic tx_nxt, done_nxt, baud_end, last_stop, hs;
`ifdef UART_TX_PARITY_EN
  localparam logic ODD = PARITY_ODD != 0;
  logic par, par_nxt;
`endif
  assign baud_end = baud_cnt == BLAST;
  assign last_stop = state == STOP && baud_end && bit_cnt == SLAST;
  assign o_ready = i_rst_n && (state == IDLE || last_stop);
  assign hs = i_valid && o_ready;
  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      o_uart_tx <= 1'b1;
      o_uart_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt <= bit_nxt;
      shreg <= sh_nxt;
      o_uart_tx <= tx_nxt;
      o_uart_tx_done <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par <= par_nxt;
`endif
    end
  end
  // every state change happens on baud_end, so the baud counter wraps with it
  always_comb begin
    state_nxt = state;
    bit_nxt = bit_cnt;
    sh_nxt = shreg;
    done_nxt = 1'b0;
    baud_nxt = (state == IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
    par_nxt = hs ? ((^i_data) ^ ODD) : par;
`endif
    unique case (state)
      IDLE: begin
        state_nxt = hs ? START : IDLE;
        sh_nxt = hs ? i_data : shreg;
      end
      START: state_nxt = baud_end ? DATA : START;
      DATA: if (baud_end) begin
        bit_nxt = bit_cnt == DLAST ? '0 : bit_cnt + 1'b1;
        sh_nxt = shreg >> 1;
`ifdef UART_TX_PARITY_EN
        state_nxt = bit_cnt == DLAST ? PARITY : DATA;
`else
        state_nxt = bit_cnt == DLAST ? STOP : DATA;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_nxt = baud_end ? STOP : PARITY;
`endif
      STOP: if (baud_end) begin
        bit_nxt = last_stop ? '0 : bit_cnt + 1'b1;
        done_nxt = last_stop;
        state_nxt = last_stop ? (hs ? START : IDLE) : STOP;
        sh_nxt = hs ? i_data : shreg;
      end
      default: state_nxt = IDLE;
    endcase
    // line is registered from the next state so the start bit appears on the handshake edge
`ifdef UART_TX_PARITY_EN
    tx_nxt = state_nxt == START ? 1'b0 : state_nxt == DATA ? sh_nxt[0] :
             state_nxt == PARITY ? par_nxt : 1'b1;
`else
    tx_nxt = state_nxt == START ? 1'b0 : state_nxt == DATA ? sh_nxt[0] : 1'b1;
`endif
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame in 8N1 and 7-bit/2-stop builds.
module tb_uart_tx_frame;
  localparam int CF = 50_000_000;
  localparam int BR = 5_000_000;
  localparam int BD = CF / BR;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic i_sysclk = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 i_sysclk = ~i_sysclk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int DB = g == 0 ? 8 : 7;
    localparam int SB = g == 0 ? 1 : 2;
    localparam int PO = g;
    localparam int F = BD * (1 + DB + P + SB);
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic ready, tx, done;
    logic [DB-1:0] data = '0;
    bit line_q[$];
    int done_q[$];
    int cyc = 0;
    bit live = 1'b0;
    bit fin = 1'b0;
    bit exp_tx, exp_done;

    uart_tx_frame #(
      .CLOCK_FREQ(CF), .BAUD(BR), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)
    ) dut (
      .i_sysclk(i_sysclk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
      .o_ready(ready), .o_uart_tx(tx), .o_uart_tx_done(done)
    );

    // expected line is one queue entry per cycle, built from the frame layout at the handshake
    always @(negedge i_sysclk) if (live) begin
      cyc++;
      check($sformatf("cfg%0d ready", g), int'(ready), int'(rst_n && line_q.size() <= 1));
      exp_tx = 1'b1;
      if (line_q.size() > 0) exp_tx = line_q.pop_front();
      exp_done = done_q.size() > 0 && done_q[0] == cyc;
      if (exp_done) void'(done_q.pop_front());
      check($sformatf("cfg%0d tx", g), int'(tx), int'(exp_tx));
      check($sformatf("cfg%0d done", g), int'(done), int'(exp_done));
      if (!rst_n) begin
        line_q.delete();
        done_q.delete();
      end else if (valid && ready) begin
        repeat (BD) line_q.push_back(1'b0);
        for (int b = 0; b < DB; b++) repeat (BD) line_q.push_back(data[b]);
        if (P == 1) repeat (BD) line_q.push_back((^data) ^ (PO != 0));
        repeat (SB * BD) line_q.push_back(1'b1);
        done_q.push_back(cyc + 1 + F);
      end
    end

    task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) begin
        @(posedge i_sysclk);
        #1 data = DB'($urandom);
      end
    endtask

    task automatic send(input int w);
      int n = 0;
      data = DB'(w);
      valid = 1'b1;
      while (!ready && n < 3 * F) begin
        @(posedge i_sysclk);
        #1;
        n++;
      end
      check($sformatf("cfg%0d handshake", g), int'(ready), 1);
      if (ready) begin
        @(posedge i_sysclk);
        #1 valid = 1'b0;
        data = DB'($urandom);
      end
    endtask

    initial begin
      @(posedge i_sysclk);
      #1 live = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send(32'h55);
      idle(F + 4);
      send(32'hA5);
      send(32'h3C);
      idle(F + 4);
      send(32'h07);
      idle(3);
      send(32'h41);
      idle(F + 4);
      send(32'h00);
      idle(4);
      data = '1;
      valid = 1'b0;
      repeat (F) @(posedge i_sysclk);
      #1 idle(4);
      send(32'h55);
      idle(45);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      send(32'h55);
      idle(F + 4);
      repeat (16) begin
        send(int'($urandom));
        idle($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 40)) : 0);
      end
      idle(F + 4);
      fin = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(cfg[0].fin && cfg[1].fin) && n < 60000) begin
      @(posedge i_sysclk);
      n++;
    end
    check("run complete", int'(cfg[0].fin && cfg[1].fin), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
